// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/countdown bundle between the phase sequencer and the display side.
// The night input exists only when NIGHT_FLASH_EN is defined.
interface traffic_phase_ctrl_if;
    logic       en;
`ifdef NIGHT_FLASH_EN
    logic       night;
`endif
    logic [4:0] s_ch1;
    logic [4:0] s_dv1;
    logic [4:0] s_ch2;
    logic [4:0] s_dv2;
    logic [2:0] light1;
    logic [2:0] light2;
    logic       tick;

    modport master (
        input  en,
`ifdef NIGHT_FLASH_EN
        input  night,
`endif
        output s_ch1, s_dv1, s_ch2, s_dv2,
        output light1, light2, tick
    );

    modport slave (
        output en,
`ifdef NIGHT_FLASH_EN
        output night,
`endif
        input  s_ch1, s_dv1, s_ch2, s_dv2,
        input  light1, light2, tick
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection sequencer with per-road BCD countdowns.
// Define NIGHT_FLASH_EN to add the night flashing-yellow mode.
module traffic_phase_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_T  = 25,
    parameter int YELLOW_T = 3
) (
    input logic                      clk,
    input logic                      rst_n,
    traffic_phase_ctrl_if.master     bus
);
    localparam int RED_T = GREEN_T + YELLOW_T;
    localparam int CW    = $clog2(TICK_DIV);

    localparam logic [CW-1:0] LAST  = CW'(TICK_DIV - 1);
    localparam logic [7:0]    G_BCD = {4'(GREEN_T / 10), 4'(GREEN_T % 10)};
    localparam logic [7:0]    Y_BCD = {4'(YELLOW_T / 10), 4'(YELLOW_T % 10)};
    localparam logic [7:0]    R_BCD = {4'(RED_T / 10), 4'(RED_T % 10)};

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

`ifdef NIGHT_FLASH_EN
    typedef enum logic [2:0] {G1R2, Y1R2, R1G2, R1Y2, NIGHT} state_t;
`else
    typedef enum logic [1:0] {G1R2, Y1R2, R1G2, R1Y2} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          tick_q;
    logic [7:0]    r1_q, r1_d;
    logic [7:0]    r2_q, r2_d;
    logic [2:0]    l1_q, l1_d;
    logic [2:0]    l2_q, l2_d;
    logic          r1_one, r2_one;
`ifdef NIGHT_FLASH_EN
    logic          flash_q, flash_d;
`endif

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign r1_one = (r1_q == 8'h01);
    assign r2_one = (r2_q == 8'h01);

    // The wrap tick is registered here regardless of what en does next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= bus.en && (cnt_q == LAST);
            if (bus.en)
                cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= G1R2;
            r1_q    <= G_BCD;
            r2_q    <= R_BCD;
            l1_q    <= L_GRN;
            l2_q    <= L_RED;
`ifdef NIGHT_FLASH_EN
            flash_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
`ifdef NIGHT_FLASH_EN
            flash_q <= flash_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
`ifdef NIGHT_FLASH_EN
        flash_d = flash_q;
`endif
        if (tick_q) begin
            unique case (state_q)
                G1R2: begin
                    r1_d = r1_one ? Y_BCD : bcd_dec(r1_q);
                    r2_d = r2_one ? G_BCD : bcd_dec(r2_q);
                    if (r1_one) state_d = Y1R2;
                end
                Y1R2: begin
                    r1_d = r1_one ? R_BCD : bcd_dec(r1_q);
                    r2_d = r2_one ? G_BCD : bcd_dec(r2_q);
                    if (r1_one) state_d = R1G2;
                end
                R1G2: begin
                    r1_d = r1_one ? G_BCD : bcd_dec(r1_q);
                    r2_d = r2_one ? Y_BCD : bcd_dec(r2_q);
                    if (r2_one) state_d = R1Y2;
                end
                R1Y2: begin
                    r1_d = r1_one ? G_BCD : bcd_dec(r1_q);
                    r2_d = r2_one ? R_BCD : bcd_dec(r2_q);
                    if (r2_one) state_d = G1R2;
                end
`ifdef NIGHT_FLASH_EN
                NIGHT: begin
                end
`endif
            endcase
        end
`ifdef NIGHT_FLASH_EN
        // Night overrides everything; leaving waits for the next tick.
        if (bus.night) begin
            r1_d = '0;
            r2_d = '0;
            if (state_q != NIGHT) begin
                state_d = NIGHT;
                flash_d = 1'b1;
            end else if (tick_q) begin
                flash_d = ~flash_q;
            end
        end else if (state_q == NIGHT) begin
            r1_d = '0;
            r2_d = '0;
            if (tick_q) begin
                state_d = G1R2;
                r1_d    = G_BCD;
                r2_d    = R_BCD;
            end
        end
`endif
    end

    always_comb begin
        l1_d = L_GRN;
        l2_d = L_RED;
        unique case (state_d)
            G1R2: begin l1_d = L_GRN; l2_d = L_RED; end
            Y1R2: begin l1_d = L_YEL; l2_d = L_RED; end
            R1G2: begin l1_d = L_RED; l2_d = L_GRN; end
            R1Y2: begin l1_d = L_RED; l2_d = L_YEL; end
`ifdef NIGHT_FLASH_EN
            NIGHT: begin
                l1_d = flash_d ? L_YEL : 3'b000;
                l2_d = flash_d ? L_YEL : 3'b000;
            end
`endif
        endcase
    end

    assign bus.s_ch1  = {1'b0, r1_q[7:4]};
    assign bus.s_dv1  = {1'b0, r1_q[3:0]};
    assign bus.s_ch2  = {1'b0, r2_q[7:4]};
    assign bus.s_dv2  = {1'b0, r2_q[3:0]};
    assign bus.light1 = l1_q;
    assign bus.light2 = l2_q;
    assign bus.tick   = tick_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: small-timing instance for the
// phase sequence, a second instance for the two-digit BCD borrow.
module tb_traffic_phase_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl_if bus();
    traffic_phase_ctrl_if bus2();

    traffic_phase_ctrl #(.TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    traffic_phase_ctrl #(.TICK_DIV(2), .GREEN_T(15), .YELLOW_T(5)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2)
    );

    // Expected road values and lamps after each of 14 ticks.
    int       exp_r1 [14] = '{4, 3, 2, 1, 2, 1, 7, 6, 5, 4, 3, 2, 1, 5};
    int       exp_r2 [14] = '{6, 5, 4, 3, 2, 1, 5, 4, 3, 2, 1, 2, 1, 7};
    logic [2:0] exp_l1 [14] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                                3'b010, 3'b100, 3'b100, 3'b100, 3'b100,
                                3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] exp_l2 [14] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                3'b100, 3'b001, 3'b001, 3'b001, 3'b001,
                                3'b001, 3'b010, 3'b010, 3'b100};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dig(input int v);
        logic [4:0] t;
        logic [4:0] u;
        t = 5'(v / 10);
        u = 5'(v % 10);
        return {22'd0, t, u};
    endfunction

    function automatic logic [31:0] rd1();
        return {22'd0, bus.s_ch1, bus.s_dv1};
    endfunction

    function automatic logic [31:0] rd2();
        return {22'd0, bus.s_ch2, bus.s_dv2};
    endfunction

    task automatic wait_tick(input bit which, output int n);
        logic t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            t = which ? bus2.tick : bus.tick;
        end while (!t && n < 20);
        if (!t) check("tick_timeout", 32'(t), 32'd1);
    endtask

    task automatic check_roads(input string tag, input int e1, input int e2,
                               input logic [2:0] el1, input logic [2:0] el2);
        check({tag, "_r1"}, rd1(), dig(e1));
        check({tag, "_r2"}, rd2(), dig(e2));
        check({tag, "_l1"}, 32'(bus.light1), 32'(el1));
        check({tag, "_l2"}, 32'(bus.light2), 32'(el2));
    endtask

    initial begin
        int n;
        int ticks;
        bus.en  = 1'b1;
        bus2.en = 1'b1;
`ifdef NIGHT_FLASH_EN
        bus.night  = 1'b0;
        bus2.night = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_roads("reset", 5, 7, 3'b001, 3'b100);
        check("reset_tick", 32'(bus.tick), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            wait_tick(1'b0, n);
            check($sformatf("period%0d", k + 1), n, (k == 0) ? 4 : 3);
            @(negedge clk);
            check_roads($sformatf("t%0d", k + 1), exp_r1[k], exp_r2[k],
                        exp_l1[k], exp_l2[k]);
        end

        wait_tick(1'b0, n);
        @(negedge clk);
        check_roads("t15", 4, 6, 3'b001, 3'b100);
        bus.en = 1'b0;
        ticks = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tick) ticks++;
        end
        check("freeze_ticks", ticks, 0);
        check_roads("freeze", 4, 6, 3'b001, 3'b100);
        bus.en = 1'b1;
        wait_tick(1'b0, n);
        check("resume_period", n, 3);
        @(negedge clk);
        check_roads("t16", 3, 5, 3'b001, 3'b100);

        for (int k = 0; k < 3; k++) begin
            wait_tick(1'b0, n);
            @(negedge clk);
        end
        check_roads("t19", 2, 2, 3'b010, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check_roads("async_rst", 5, 7, 3'b001, 3'b100);
        check("async_rst_tick", 32'(bus.tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) @(negedge clk);
        check("wrap_tick", 32'(bus.tick), 32'd1);
        bus.en = 1'b0;
        @(negedge clk);
        check_roads("en_wrap", 4, 6, 3'b001, 3'b100);
        check("en_wrap_tick", 32'(bus.tick), 32'd0);
        repeat (5) @(negedge clk);
        check_roads("en_hold", 4, 6, 3'b001, 3'b100);
        bus.en = 1'b1;

        check("bcd_reset", {22'd0, bus2.s_ch2, bus2.s_dv2}, dig(20));
        rst2_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wait_tick(1'b1, n);
            @(negedge clk);
            check($sformatf("bcd%0d", k), {22'd0, bus2.s_ch2, bus2.s_dv2},
                  dig((k < 20) ? 20 - k : 15));
        end

`ifdef NIGHT_FLASH_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wait_tick(1'b0, n);
            @(negedge clk);
        end
        check_roads("pre_night", 7, 5, 3'b100, 3'b001);
        bus.night = 1'b1;
        @(negedge clk);
        check_roads("night_in", 0, 0, 3'b010, 3'b010);
        wait_tick(1'b0, n);
        @(negedge clk);
        check_roads("night_off", 0, 0, 3'b000, 3'b000);
        wait_tick(1'b0, n);
        @(negedge clk);
        check_roads("night_on", 0, 0, 3'b010, 3'b010);
        bus.night = 1'b0;
        @(negedge clk);
        check_roads("night_wait", 0, 0, 3'b010, 3'b010);
        wait_tick(1'b0, n);
        @(negedge clk);
        check_roads("night_exit", 5, 7, 3'b001, 3'b100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Sequencer for a two-road intersection; drives the lamp outputs and supplies the BCD countdown digits consumed by the display block (tens/units per road, 5-bit each).
- Divides the system clock down to a 1-second tick.
- Steps a four-phase state machine and maintains two per-road BCD down-counters showing the remaining seconds of each road's current colour.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1-second tick; legal range ≥ 2.
- GREEN_T, 25, green duration in seconds; legal range 2..90.
- YELLOW_T, 3, yellow duration in seconds; legal range 1..9.
- Red duration is derived: RED_T = GREEN_T + YELLOW_T; must be ≤ 99.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable; low freezes prescaler, counters and state
- s_ch1  output  5  road1 tens digit, 0..9, bit4 always 0
- s_dv1  output  5  road1 units digit, 0..9, bit4 always 0
- s_ch2  output  5  road2 tens digit
- s_dv2  output  5  road2 units digit
- light1  output  3  road1 lamps {red,yellow,green}, one-hot
- light2  output  3  road2 lamps {red,yellow,green}, one-hot
- tick  output  1  one-cycle pulse at each second boundary

Behaviour:
- Reset (async assert, sync-free deassert) sets:
  - state = G1R2, prescaler = 0, tick = 0
  - road1 digits = BCD(GREEN_T); road2 digits = BCD(RED_T)
  - light1 = 3'b001, light2 = 3'b100
- Prescaler:
  - Counts 0..TICK_DIV-1 while en = 1.
  - tick is registered, high for exactly one cycle when the count wraps from TICK_DIV-1 to 0.
  - en = 0 holds the count; no tick is issued.
- States and lamps:
  - G1R2: light1 green, light2 red.
  - Y1R2: light1 yellow, light2 red.
  - R1G2: light1 red, light2 green.
  - R1Y2: light1 red, light2 yellow.
  - Sequence G1R2 → Y1R2 → R1G2 → R1Y2 → G1R2.
- Countdown per road, on each tick:
  - If the road's value > 1: BCD decrement (units 0 borrows → units 9, tens−1).
  - If the road's value == 1: reload with the duration of that road's next colour.
- Transitions and reloads:
  - The state changes on the tick at which the road whose phase ends (the green/yellow road) reads 1.
  - G1R2→Y1R2: road1 reloads YELLOW_T.
  - Y1R2→R1G2: road1 reloads RED_T, road2 reloads GREEN_T.
  - R1G2→R1Y2: road2 reloads YELLOW_T.
  - R1Y2→G1R2: road2 reloads RED_T, road1 reloads GREEN_T.
  - The red road counts continuously RED_T..1 across two phases, reaching 1 on the same tick as the opposing yellow road.
- Each phase lasts exactly its duration in ticks. Displayed values never show 0 in normal operation.
- All outputs are registered. Lamps and digits change in the cycle after tick is sampled, i.e. concurrently with the tick pulse's fall.
- Simultaneous events:
  - en falling on the same cycle as a wrap: that tick is honoured.
  - Subsequent cycles hold all state.
- Reset mid-phase: immediate return to the reset values; no partial tick is retained.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- When defined:
  - Adds input port night (1 bit).
  - While night = 1, the state is NIGHT: light1 = light2 = yellow on odd ticks and all-off (3'b000) on even ticks, starting with yellow on entry. All four digit outputs are 0.
  - Entry to NIGHT occurs on the first clk edge with night = 1, from any state.
  - On night falling, the block waits for the next tick, then enters G1R2 with reset-equivalent digit values.
  - The prescaler is not reset by night.
- When undefined: no night port, no NIGHT state, behaviour exactly as above.

Test Plan:
- TICK_DIV=4, GREEN_T=5, YELLOW_T=2, reset released, en=1 → road1 digits 0,5 / road2 0,7 at reset; tick every 4 cycles; road1 reads 5,4,3,2,1 then yellow 2,1, while road2 reads 7..1 and turns green on the same tick road1 turns red.
- Full cycle run of 14 ticks → states G1R2(5), Y1R2(2), R1G2(5), R1Y2(2), back to G1R2 with road1=5, road2=7; lamps stay one-hot throughout.
- GREEN_T=15, YELLOW_T=5 (RED_T=20) → road2 tens/units pass 2,0 → 1,9 → … → 1,0 → 0,9: correct BCD borrow; tens never exceeds 2.
- en driven low for 10 cycles mid-phase → no tick, digits and lamps frozen; on en high, the prescaler resumes from its held count.
- rst_n asserted asynchronously between clk edges during Y1R2 → outputs return to reset values before the next clk edge.
- NIGHT_FLASH_EN defined, night=1 during R1G2 → next edge: digits all 0, lamps yellow; they alternate off/yellow per tick. night=0 → at the next tick: G1R2, road1=5, road2=7.
